match_run_recorder: RTL and testbench
=====================================

Name: match_run_recorder

Overview:
- Downstream consumer of the run-of-equal-w detector. It samples that detector's registered match output (z) and its idle flag (InIdle).
- Measures the length in clock cycles of every contiguous match run and queues each completed length in a small FIFO. A host reads the FIFO through a valid/ready port.
- Also keeps a saturating count of completed runs, plus sticky overflow and protocol-error flags.

Parameters:
- LEN_W, 8: width of a run-length entry; the length counter saturates at 2^LEN_W-1.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16: width of run_count; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- match  in  1  detector match output; 1 means the detector is in its 4-or-more state.
- in_idle  in  1  detector idle flag.
- rd_ready  in  1  host accepts the head entry this cycle.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  LEN_W  head entry length; 0 when the FIFO is empty.
- run_count  out  CNT_W  completed runs since reset, including dropped runs.
- active  out  1  a run is currently being measured.
- overflow  out  1  sticky; a completed run was dropped because the FIFO was full.
- proto_err  out  1  sticky; match and in_idle were both 1 in the same cycle.

Behaviour:
- Reset (rst=1 at an edge): state=WAIT, len=0, FIFO pointers and occupancy=0, run_count=0, overflow=0, proto_err=0.
  - Outputs after reset: rd_valid=0, rd_data=0, active=0.
  - Reset mid-run discards the partial run; no push occurs.
  - Reset overrides every other event in the same cycle.
- FSM, two states, registered:
  - WAIT, match=1: go to RUN, len<=1.
  - WAIT, match=0: stay in WAIT.
  - RUN, match=1: stay in RUN; len<=len+1, saturating at 2^LEN_W-1 (no wrap).
  - RUN, match=0: the run is complete; push request with data=len, go to WAIT, len<=0.
- active = (state==RUN), registered. It goes high the edge after match is first sampled 1 and low the edge after match is first sampled 0.
- Run length = number of consecutive edges at which match was sampled 1.
- Back-to-back runs: match 1,0,1 yields two runs of length 1. A single low sample terminates a run.
- Push latency: the entry is written at the edge where match is first sampled 0. rd_valid rises on the following cycle, if the FIFO was empty.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read/write pointers and a separate occupancy counter of log2(DEPTH)+1 bits.
  - rd_data = mem[rd_ptr] when occupancy>0, else 0. Combinational from registers.
  - Pop occurs when rd_valid && rd_ready. rd_ready with an empty FIFO has no effect.
  - Push when not full: write at wr_ptr, wr_ptr wraps modulo DEPTH.
  - Push when full with no pop in the same cycle: entry dropped, overflow<=1, FIFO unchanged.
  - Push and pop in the same cycle: both take effect, occupancy unchanged, no drop even when full.
  - Pointers wrap silently; occupancy never exceeds DEPTH.
- run_count increments by 1 on every completed run, dropped or not, and saturates at 2^CNT_W-1.
- proto_err <= 1 at any edge where match=1 and in_idle=1. It is cleared only by rst.
- in_idle has no other effect on measurement.

Test Plan:
- Reset, then match high for 5 cycles then low -> rd_valid=1 one cycle after the first low sample; rd_data=5; run_count=1; active high for exactly 5 cycles.
- match pattern 1,0,1,1,0 with rd_ready=0 -> FIFO holds 1 then 2; rd_ready=1 for 2 cycles pops 1 then 2; rd_valid=0 afterwards and rd_data=0.
- DEPTH=4, five runs of length 3 with rd_ready=0 -> 4 entries stored, overflow=1, run_count=5. The fifth run completes while the FIFO is full, with rd_ready=1 on that same cycle -> no drop, overflow stays 0, occupancy stays 4.
- LEN_W=8, match high for 300 cycles -> rd_data=255 (saturated); run_count=1.
- rst asserted at cycle 3 of a 6-cycle run, released at cycle 4 with match still high -> partial run discarded. A new run starts at the first post-reset edge where match=1; the recorded length counts only post-reset samples.
- match=1 with in_idle=1 for one cycle -> proto_err=1 from the next cycle until rst; the run-length result is unaffected.

Source files
------------

// File: rtl/match_run_recorder_if.sv
// Bus between the run-length recorder, its upstream detector and the reading host.
// The slave modport is the recorder side. The master modport is the detector/host side.
interface match_run_recorder_if #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic             match;
  logic             in_idle;
  logic             rd_ready;
  logic             rd_valid;
  logic [LEN_W-1:0] rd_data;
  logic [CNT_W-1:0] run_count;
  logic             active;
  logic             overflow;
  logic             proto_err;

  modport slave (
    input  match, in_idle, rd_ready,
    output rd_valid, rd_data, run_count, active, overflow, proto_err
  );

  modport master (
    output match, in_idle, rd_ready,
    input  rd_valid, rd_data, run_count, active, overflow, proto_err
  );
endinterface

// File: rtl/match_run_recorder.sv
// Measures contiguous match runs from the run-of-equal-w detector and queues each length in a FIFO.
// It also keeps a saturating run counter and sticky overflow and protocol-error flags.
module match_run_recorder #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  match_run_recorder_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_occ;
  logic [CNT_W-1:0] r_run_count;
  logic             r_overflow;
  logic             r_proto_err;
  logic [LEN_W-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_rd_valid;

  assign w_rd_valid = (r_occ != '0);
  assign w_full     = (r_occ == (PTR_W+1)'(DEPTH));
  assign w_push     = (r_state == ST_RUN) && !bus.match;
  assign w_pop      = w_rd_valid && bus.rd_ready;
  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
  assign w_push_ok  = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_WAIT;
      r_len       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_run_count <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (bus.match) begin
            r_state <= ST_RUN;
            r_len   <= LEN_W'(1);
          end
        end
        default: begin
          if (bus.match) begin
            if (r_len != '1)
              r_len <= r_len + LEN_W'(1);
          end else begin
            r_state <= ST_WAIT;
            r_len   <= '0;
          end
        end
      endcase

      if (w_push && r_run_count != '1)
        r_run_count <= r_run_count + CNT_W'(1);

      if (w_push && !w_push_ok)
        r_overflow <= 1'b1;

      if (bus.match && bus.in_idle)
        r_proto_err <= 1'b1;

      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      if (w_push_ok && !w_pop)
        r_occ <= r_occ + (PTR_W+1)'(1);
      else if (!w_push_ok && w_pop)
        r_occ <= r_occ - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok)
      r_mem[r_wr_ptr] <= r_len;
  end

  assign bus.rd_valid  = w_rd_valid;
  assign bus.rd_data   = w_rd_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.run_count = r_run_count;
  assign bus.active    = (r_state == ST_RUN);
  assign bus.overflow  = r_overflow;
  assign bus.proto_err = r_proto_err;
endmodule

// File: tb/tb_match_run_recorder.sv
// Scoreboard bench for match_run_recorder.
// Stimulus queues hand-computed run lengths, and a negedge monitor checks every popped entry against them.
module tb_match_run_recorder;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [LEN_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  match_run_recorder_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut_if ();

  match_run_recorder #(.LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  always @(negedge clk) begin
    if (!rst && dut_if.rd_valid && dut_if.rd_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got rd_data=%0d, expected no entry", dut_if.rd_data);
      end else begin
        logic [LEN_W-1:0] e;
        e = exp_q.pop_front();
        if (dut_if.rd_data !== e) begin
          bad++;
          $display("FAIL pop_data: got %0d, expected %0d", dut_if.rd_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic idle, input logic rdy);
    dut_if.match    = m;
    dut_if.in_idle  = idle;
    dut_if.rd_ready = rdy;
    tick();
  endtask

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // The run is n cycles of match high followed by one low cycle; the low cycle carries rdy_on_end.
  task automatic run(input int n, input logic rdy_on_end);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, rdy_on_end);
    dut_if.rd_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    dut_if.rd_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2 && dut_if.rd_valid; i++) tick();
    dut_if.rd_ready = 1'b0;
    check({name, "_empty"}, dut_if.rd_valid, 0);
  endtask

  initial begin
    dut_if.match    = 1'b0;
    dut_if.in_idle  = 1'b0;
    dut_if.rd_ready = 1'b0;
    do_reset();
    check("rst_valid", dut_if.rd_valid, 0);
    check("rst_data", dut_if.rd_data, 0);
    check("rst_active", dut_if.active, 0);
    check("rst_count", dut_if.run_count, 0);
    check("rst_ovf", dut_if.overflow, 0);
    check("rst_perr", dut_if.proto_err, 0);

    // A single run of length 5 sets active on each match-high edge and keeps the FIFO empty until the run ends.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      check("r5_active", dut_if.active, 1);
      check("r5_valid_during", dut_if.rd_valid, 0);
    end
    drive(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'd5);
    check("r5_active_off", dut_if.active, 0);
    check("r5_valid", dut_if.rd_valid, 1);
    check("r5_head", dut_if.rd_data, 5);
    check("r5_count", dut_if.run_count, 1);
    drain("r5");

    // The pattern 1,0,1,1,0 yields two runs, of length 1 and then length 2.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    check("b2b_count", dut_if.run_count, 3);
    dut_if.rd_ready = 1'b1;
    tick();
    tick();
    dut_if.rd_ready = 1'b0;
    check("b2b_valid", dut_if.rd_valid, 0);
    check("b2b_data", dut_if.rd_data, 0);

    // Five runs into a 4-deep FIFO with no reads: the fifth run is dropped.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      run(3, 1'b0);
      exp_q.push_back(8'd3);
    end
    check("ovf_pre", dut_if.overflow, 0);
    run(3, 1'b0);
    check("ovf_set", dut_if.overflow, 1);
    check("ovf_count", dut_if.run_count, 5);
    drain("ovf");

    // The fifth run completes while the FIFO is full and a read happens in the same cycle: nothing is dropped.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      run(3, 1'b0);
      exp_q.push_back(8'd3);
    end
    exp_q.push_back(8'd3);
    run(3, 1'b1);
    check("fullpp_ovf", dut_if.overflow, 0);
    check("fullpp_count", dut_if.run_count, 5);
    dut_if.rd_ready = 1'b1;
    tick();
    tick();
    tick();
    check("fullpp_valid3", dut_if.rd_valid, 1);
    tick();
    dut_if.rd_ready = 1'b0;
    check("fullpp_valid4", dut_if.rd_valid, 0);

    // A 300-cycle run saturates the length counter at 255.
    do_reset();
    run(300, 1'b0);
    exp_q.push_back(8'd255);
    check("sat_count", dut_if.run_count, 1);
    check("sat_head", dut_if.rd_data, 255);
    drain("sat");

    // Reset in the middle of a run discards the partial run; the next run counts only post-reset samples.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_active", dut_if.active, 0);
    check("mid_rst_valid", dut_if.rd_valid, 0);
    run(3, 1'b0);
    exp_q.push_back(8'd3);
    check("mid_rst_count", dut_if.run_count, 1);
    drain("mid_rst");

    // proto_err is set only when match and in_idle are both high, and the run length is unaffected.
    drive(1'b0, 1'b1, 1'b0);
    check("perr_idle_only", dut_if.proto_err, 0);
    drive(1'b1, 1'b1, 1'b0);
    check("perr_set", dut_if.proto_err, 1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'd3);
    drain("perr");
    check("perr_sticky", dut_if.proto_err, 1);
    do_reset();
    check("perr_cleared", dut_if.proto_err, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
